// File: rtl/wb_commit_if.sv
// Handshake and bus bundle between the memory stage, the writeback stage and the register file.
// The slave modport is the writeback stage; the master modport is everything around it.
interface wb_commit_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int CNTW = 64
);
    localparam int RW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_mem;
    logic [2:0]      in_addr_lo;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic            in_mem_r;
    logic            in_link;
    logic [RW-1:0]   in_rd;
    logic            in_reg_w;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_reg_w;
    logic [RW-1:0]   out_rd;
    logic [XLEN-1:0] out_data;
    logic [XLEN-1:0] out_pc;
    logic [CNTW-1:0] retire_cnt;

    modport slave (
        input  in_valid, in_pc, in_alu, in_mem, in_addr_lo, in_size, in_unsigned,
               in_mem_r, in_link, in_rd, in_reg_w, flush, out_ready,
        output in_ready, out_valid, out_reg_w, out_rd, out_data, out_pc, retire_cnt
    );

    modport master (
        output in_valid, in_pc, in_alu, in_mem, in_addr_lo, in_size, in_unsigned,
               in_mem_r, in_link, in_rd, in_reg_w, flush, out_ready,
        input  in_ready, out_valid, out_reg_w, out_rd, out_data, out_pc, retire_cnt
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: selects link/load/ALU result and presents it to the register file.
// Latency 1 cycle accept-to-out_valid; in_ready = !out_valid | out_ready, outputs hold while stalled.
module wb_commit #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int CNTW = 64
) (
    input  logic        clk,
    input  logic        rst,
    wb_commit_if.slave  bus
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    logic [2:0]      off;
    logic [1:0]      sz;
    logic [6:0]      nbits;
    logic [SW-1:0]   msb;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ld;
    logic [XLEN-1:0] sel;

    logic            valid_q;
    logic            regw_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;
    logic [CNTW-1:0] cnt_q;

    logic accept;
    logic retire;

    // Load extraction: sign/zero fill is done with a mask above the selected width,
    // so straddling offsets simply yield the shifted, truncated word.
    always_comb begin
        off = bus.in_addr_lo;
        sz  = bus.in_size;
        if (XLEN == 32) begin
            off[2] = 1'b0;
            if (sz == 2'd3) sz = 2'd2;
        end
        shifted = bus.in_mem >> {off, 3'b000};
        case (sz)
            2'd0:    nbits = 7'd8;
            2'd1:    nbits = 7'd16;
            2'd2:    nbits = 7'd32;
            default: nbits = 7'd64;
        endcase
        msb  = SW'(nbits - 7'd1);
        mask = {XLEN{1'b1}} << nbits;
        ld   = (shifted & ~mask) | ((!bus.in_unsigned && shifted[msb]) ? mask : '0);
        if (bus.in_link)
            sel = bus.in_pc + XLEN'(4);
        else if (bus.in_mem_r)
            sel = ld;
        else
            sel = bus.in_alu;
    end

    assign bus.in_ready = !valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & !bus.flush;
    assign retire       = valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            regw_q  <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                regw_q  <= bus.in_reg_w & (bus.in_rd != '0);
                rd_q    <= bus.in_rd;
                data_q  <= sel;
                pc_q    <= bus.in_pc;
            end else if (bus.flush || retire) begin
                valid_q <= 1'b0;
            end
            if (retire) cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_reg_w  = valid_q & regw_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_data   = data_q;
    assign bus.out_pc     = pc_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter NREG, default 32, architectural register count; RW = $clog2(NREG).
REQ-003 Parameter CNTW, default 64, width of retire counter.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream (memory stage) holds a valid instruction.
REQ-007 in_ready  out  1  block can accept this cycle.
REQ-008 in_pc  in  XLEN  instruction PC.
REQ-009 in_alu  in  XLEN  ALU result.
REQ-010 in_mem  in  XLEN  raw aligned load data word.
REQ-011 in_addr_lo  in  3  load byte offset within word (bit 2 ignored when XLEN=32).
REQ-012 in_size  in  2  load size: 0 byte, 1 half, 2 word, 3 double.
REQ-013 in_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-014 in_mem_r  in  1  instruction is a load.
REQ-015 in_link  in  1  instruction is JAL/JALR.
REQ-016 in_rd  in  RW  destination register.
REQ-017 in_reg_w  in  1  instruction writes rd.
REQ-018 flush  in  1  discard held and incoming instruction.
REQ-019 out_valid  out  1  retiring instruction presented.
REQ-020 out_ready  in  1  register file/commit side accepts.
REQ-021 out_reg_w  out  1  register write enable, qualified (see REQ-027).
REQ-022 out_rd  out  RW  register write index.
REQ-023 out_data  out  XLEN  register write data.
REQ-024 out_pc  out  XLEN  PC of retiring instruction.
REQ-025 retire_cnt  out  CNTW  count of retired instructions.

Function
REQ-026 Single registered stage; result selected combinationally from inputs and captured on accept; latency one cycle accept-to-out_valid.
REQ-027 out_reg_w = out_valid & captured reg_w & (captured rd != 0); never asserted while out_valid=0.
REQ-028 Data select priority: in_link -> in_pc+4 (mod 2^XLEN); else in_mem_r -> extracted load; else in_alu.
REQ-029 Load extract: shift in_mem right by 8*in_addr_lo; take low 8/16/32/64 bits per in_size; extend to XLEN per in_unsigned.
REQ-030 XLEN=32: in_size=3 treated as size 2; in_addr_lo[2] ignored.
REQ-031 Size/offset combinations that straddle the word are not checked; result is the shifted, truncated value.
REQ-032 in_ready = !out_valid | out_ready (combinational; no dependence on in_valid).
REQ-033 Accept = in_valid & in_ready & !flush; on accept all out_* registers load new values.
REQ-034 While out_valid & !out_ready, out_valid, out_rd, out_reg_w, out_data, out_pc hold stable.
REQ-035 Retire = out_valid & out_ready; retire without accept clears out_valid next cycle.
REQ-036 Retire and accept same cycle: out_valid stays 1, new instruction presented next cycle (back-to-back, one per cycle).
REQ-037 flush=1: out_valid cleared next cycle, no accept that cycle; a retire occurring in the flush cycle still counts.
REQ-038 retire_cnt increments by 1 on each retire; wraps 2^CNTW-1 -> 0.

Reset
REQ-039 rst=1 at posedge: out_valid=0, out_reg_w=0, out_rd=0, out_data=0, out_pc=0, retire_cnt=0.
REQ-040 rst overrides flush, accept and retire; held instruction discarded, not counted.
REQ-041 After rst deasserts, in_ready=1 in the first cycle.

Verification
REQ-042 ALU op: in_alu=0x1234, rd=5, reg_w=1, out_ready=1 -> next cycle out_valid=1, out_reg_w=1, out_rd=5, out_data=0x1234; retire_cnt 0->1.
REQ-043 Load: in_mem=0x0000_0000_8000_FF00, addr_lo=1, size=0, unsigned=0 -> out_data=0xFFFF_FFFF_FFFF_FFFF; same with unsigned=1 -> 0xFF.
REQ-044 JAL: in_pc=0x8000_0000, in_link=1, in_alu=0x55 -> out_data=0x8000_0004; rd=0, reg_w=1 -> out_reg_w=0 but retire_cnt increments.
REQ-045 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable 3 cycles; out_ready=1 -> held retires, next accepted same cycle, out_valid stays 1.
REQ-046 Flush: held instruction plus in_valid=1 with flush=1, out_ready=0 -> out_valid=0 next cycle, retire_cnt unchanged; CNTW=4 count 15 then retire -> 0.
REQ-047 rst mid-stall (out_valid=1, out_ready=0) -> all outputs 0, retire_cnt=0, in_ready=1 next cycle.
